// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 packet sequencer.
package max7219_pkg;

  localparam logic [7:0] REG_DIG0    = 8'h01;
  localparam logic [7:0] REG_DECODE  = 8'h09;
  localparam logic [7:0] REG_INTENS  = 8'h0A;
  localparam logic [7:0] REG_SCANLIM = 8'h0B;
  localparam logic [7:0] REG_SHUTDN  = 8'h0C;
  localparam logic [7:0] REG_TEST    = 8'h0F;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    REL
  } state_t;

  typedef enum logic {
    PH_INIT,
    PH_UPD
  } phase_t;

endpackage

// File: rtl/max7219_lzb.sv
// Leading-zero blanking of a BCD digit vector; the lowest digit always shows.
import max7219_pkg::*;

module max7219_lzb #(
  parameter int NDIG = 4
) (
  input  logic [4*NDIG-1:0] digits,
  output logic [4*NDIG-1:0] blanked
);

  logic lead;

  always_comb begin
    blanked = digits;
    lead    = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      if (lead && digits[4*k +: 4] == 4'h0)
        blanked[4*k +: 4] = BLANK;
      else
        lead = 1'b0;
    end
  end

endmodule

// File: rtl/max7219_pkt_seq.sv
// MAX7219 command-word sequencer: init burst after reset, then digit refreshes.
// Define MAX7219_PKT_SEQ_LZB_EN to blank leading zeros at snapshot capture.
import max7219_pkg::*;

module max7219_pkt_seq #(
  parameter int         NDIG      = 4,
  parameter logic [3:0] INTENSITY = 4'h8,
  parameter logic [7:0] DECODE    = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd,
  input  logic [4*NDIG-1:0] digits,
  input  logic              psnt,
  output logic              preq,
  output logic [15:0]       pkt,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] LAST_INIT = 3'd4;
  localparam logic [2:0] LAST_UPD  = 3'(NDIG - 1);

  state_t              state;
  phase_t              phase;
  logic [2:0]          idx;
  logic                pend;
  logic [4*NDIG-1:0]   snap;
  logic [4*NDIG-1:0]   cap;
  logic [3:0]          dsel;
  logic [15:0]         word;
  logic [2:0]          last;

`ifdef MAX7219_PKT_SEQ_LZB_EN
  max7219_lzb #(
    .NDIG(NDIG)
  ) u_lzb (
    .digits (digits),
    .blanked(cap)
  );
`else
  assign cap = digits;
`endif

  assign last = (phase == PH_INIT) ? LAST_INIT : LAST_UPD;

  always_comb begin
    dsel = 4'h0;
    for (int i = 0; i < NDIG; i++)
      if (idx == 3'(i)) dsel = snap[4*i +: 4];
  end

  always_comb begin
    word = 16'h0000;
    if (phase == PH_UPD) begin
      word = {{5'd0, idx} + REG_DIG0, 4'h0, dsel};
    end else begin
      case (idx)
        3'd0:    word = {REG_SHUTDN, 8'h01};
        3'd1:    word = {REG_DECODE, DECODE};
        3'd2:    word = {REG_INTENS, 4'h0, INTENSITY};
        3'd3:    word = {REG_SCANLIM, 5'h0, LAST_UPD};
        default: word = {REG_TEST, 8'h00};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
      phase <= PH_INIT;
      idx   <= 3'd0;
      pend  <= 1'b0;
      snap  <= '0;
      preq  <= 1'b0;
      pkt   <= 16'h0000;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      // strobes during a sequence collapse into one deferred refresh
      if (upd && state != IDLE) pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (upd || pend) begin
            snap  <= cap;
            pend  <= 1'b0;
            phase <= PH_UPD;
            idx   <= 3'd0;
            busy  <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          pkt   <= word;
          preq  <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          if (psnt) begin
            preq  <= 1'b0;
            state <= REL;
          end
        end
        REL: begin
          if (!psnt) begin
            if (idx == last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= REQ;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_pkt_seq.sv
// Directed bench for max7219_pkt_seq with an inline pkt_snd responder.
`timescale 1ns/1ps

module tb_max7219_pkt_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic        psnt = 1'b0;
  logic        preq;
  logic [15:0] pkt;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max7219_pkt_seq #(
    .NDIG(4),
    .INTENSITY(4'h8),
    .DECODE(8'hFF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .upd   (upd),
    .digits(digits),
    .psnt  (psnt),
    .preq  (preq),
    .pkt   (pkt),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_preq(input string tag);
    int n = 0;
    while (preq !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_preq"}, {15'd0, preq}, 16'd1);
  endtask

  // mode 0: psnt pulse; mode 1: psnt level held 5 cycles
  task automatic xfer(input logic [15:0] exp, input int mode,
                      input string tag);
    logic seen;
    wait_preq(tag);
    check({tag, "_pkt"}, pkt, exp);
    repeat (20) @(negedge clk);
    check({tag, "_hold"}, pkt, exp);
    psnt = 1'b1;
    @(negedge clk);
    check({tag, "_drop"}, {15'd0, preq}, 16'd0);
    if (mode == 1) begin
      seen = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (preq) seen = 1'b1;
      end
      check({tag, "_lvl_noreq"}, {15'd0, seen}, 16'd0);
      psnt = 1'b0;
      @(negedge clk);
      check({tag, "_gap"}, {15'd0, preq}, 16'd0);
      @(negedge clk);
      check({tag, "_next"}, {15'd0, preq}, 16'd1);
    end else begin
      psnt = 1'b0;
      @(negedge clk);
      check({tag, "_gap"}, {15'd0, preq}, 16'd0);
    end
  endtask

  task automatic wait_done(input logic busy_after, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    @(negedge clk);
    check({tag, "_done1"}, {15'd0, done}, 16'd0);
    check({tag, "_busy"}, {15'd0, busy}, {15'd0, busy_after});
  endtask

  task automatic pulse_upd();
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic quiet(input string tag);
    logic seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (preq) seen = 1'b1;
    end
    check(tag, {15'd0, seen}, 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_init(input string tag);
    xfer(16'h0C01, 0, {tag, "0"});
    xfer(16'h09FF, 0, {tag, "1"});
    xfer(16'h0A08, 0, {tag, "2"});
    xfer(16'h0B03, 0, {tag, "3"});
    xfer(16'h0F00, 0, {tag, "4"});
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_preq", {15'd0, preq}, 16'd0);
    check("rst_pkt", pkt, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd1);
    check("rst_done", {15'd0, done}, 16'd0);
    rst = 1'b0;

    // init sequence
    run_init("init");
    wait_done(1'b0, "init");

    // refresh, idx1 handshake uses a held psnt level
    digits = 16'h1234;
    pulse_upd();
    xfer(16'h0104, 0, "upd0");
    xfer(16'h0203, 1, "upd1");
    xfer(16'h0302, 0, "upd2");
    xfer(16'h0401, 0, "upd3");
    wait_done(1'b0, "upd");
    quiet("upd_quiet");

    // strobes during init collapse; snapshot taken at idle exit
    do_reset();
    xfer(16'h0C01, 0, "pi0");
    pulse_upd();
    xfer(16'h09FF, 0, "pi1");
    pulse_upd();
    xfer(16'h0A08, 0, "pi2");
    digits = 16'h5678;
    pulse_upd();
    xfer(16'h0B03, 0, "pi3");
    xfer(16'h0F00, 0, "pi4");
    wait_done(1'b1, "pi");
    xfer(16'h0108, 0, "pu0");
    xfer(16'h0207, 0, "pu1");
    xfer(16'h0306, 0, "pu2");
    xfer(16'h0405, 0, "pu3");
    wait_done(1'b0, "pu");
    quiet("pend_once");

    // reset in ACK of idx2 with a pending update
    digits = 16'h1234;
    pulse_upd();
    xfer(16'h0104, 0, "ru0");
    pulse_upd();
    xfer(16'h0203, 0, "ru1");
    wait_preq("ru2");
    check("ru2_pkt", pkt, 16'h0302);
    rst = 1'b1;
    #1;
    check("ru_async_preq", {15'd0, preq}, 16'd0);
    check("ru_async_busy", {15'd0, busy}, 16'd1);
    check("ru_async_pkt", pkt, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_init("rinit");
    wait_done(1'b0, "rinit");
    quiet("no_stale");

    // leading-zero blanking (verbatim digits when disabled)
    digits = 16'h0070;
    pulse_upd();
`ifdef MAX7219_PKT_SEQ_LZB_EN
    xfer(16'h0100, 0, "lz0");
    xfer(16'h0207, 0, "lz1");
    xfer(16'h030F, 0, "lz2");
    xfer(16'h040F, 0, "lz3");
`else
    xfer(16'h0100, 0, "lz0");
    xfer(16'h0207, 0, "lz1");
    xfer(16'h0300, 0, "lz2");
    xfer(16'h0400, 0, "lz3");
`endif
    wait_done(1'b0, "lz");
    digits = 16'h0000;
    pulse_upd();
`ifdef MAX7219_PKT_SEQ_LZB_EN
    xfer(16'h0100, 0, "lzz0");
    xfer(16'h020F, 0, "lzz1");
    xfer(16'h030F, 0, "lzz2");
    xfer(16'h040F, 0, "lzz3");
`else
    xfer(16'h0100, 0, "lzz0");
    xfer(16'h0200, 0, "lzz1");
    xfer(16'h0300, 0, "lzz2");
    xfer(16'h0400, 0, "lzz3");
`endif
    wait_done(1'b0, "lzz");

    // code-B specials pass through
    digits = 16'hFEDA;
    pulse_upd();
    xfer(16'h010A, 0, "sp0");
    xfer(16'h020D, 0, "sp1");
    xfer(16'h030E, 0, "sp2");
    xfer(16'h040F, 0, "sp3");
    wait_done(1'b0, "sp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
